// File: rtl/eth_tx_responder.sv
// eth_tx_responder: builds fixed 8-byte reply frames for the MAC tx byte stream.
// Ports: i_clk/i_rst_n (async active-low); i_req_valid/i_req_cmd/i_req_data request strobe and nibbles;
// i_cur_state/i_fifo_used status snapshotted at frame start; o_tx_data/o_tx_valid/i_tx_ready/o_tx_last
// byte stream handshake; o_busy frame in progress or request pending; o_drop_count saturating drop counter.
module eth_tx_responder #(
  parameter logic [7:0] HDR_BYTE    = 8'hA5,
  parameter int         FIFO_USED_W = 11
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_req_valid,
  input  logic [3:0]             i_req_cmd,
  input  logic [3:0]             i_req_data,
  input  logic [3:0]             i_cur_state,
  input  logic [FIFO_USED_W-1:0] i_fifo_used,
  output logic [7:0]             o_tx_data,
  output logic                   o_tx_valid,
  input  logic                   i_tx_ready,
  output logic                   o_tx_last,
  output logic                   o_busy,
  output logic [7:0]             o_drop_count
);
  typedef enum logic {IDLE, SEND} state_t;
  state_t r_state, w_state_nx;
  logic [2:0]  r_idx;
  logic [7:0]  r_req, r_pend, r_seq, r_seq_snap, r_drop, r_drop_snap;
  logic        r_pend_v;
  logic [3:0]  r_cur;
  logic [15:0] r_fifo;
  logic        w_last_xfer, w_start;
  logic [7:0]  w_req, w_byte, w_sum;
  always_comb begin
    w_req       = {i_req_cmd, i_req_data};
    w_last_xfer = r_state == SEND && i_tx_ready && r_idx == 3'd7;
    // a new frame starts from idle or directly on the final-byte transfer, so back-to-back frames have no gap
    w_start     = (r_state == IDLE || w_last_xfer) && (i_req_valid || r_pend_v);
    w_state_nx  = w_start ? SEND : w_last_xfer ? IDLE : r_state;
    w_sum       = HDR_BYTE ^ r_req ^ {4'h0, r_cur} ^ r_fifo[15:8] ^ r_fifo[7:0] ^ r_seq_snap ^ r_drop_snap;
    o_tx_valid  = r_state == SEND;
    o_tx_last   = o_tx_valid && r_idx == 3'd7;
    o_busy      = o_tx_valid || r_pend_v;
    o_drop_count = r_drop;
  end
  always_comb begin
    w_byte = w_sum;
    case (r_idx)
      3'd0: w_byte = HDR_BYTE;
      3'd1: w_byte = r_req;
      3'd2: w_byte = {4'h0, r_cur};
      3'd3: w_byte = r_fifo[15:8];
      3'd4: w_byte = r_fifo[7:0];
      3'd5: w_byte = r_seq_snap;
      3'd6: w_byte = r_drop_snap;
      default: w_byte = w_sum;
    endcase
    o_tx_data = o_tx_valid ? w_byte : 8'h00;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nx;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx       <= 3'd0;
      r_req       <= 8'h00;
      r_pend      <= 8'h00;
      r_pend_v    <= 1'b0;
      r_cur       <= 4'h0;
      r_fifo      <= 16'h0000;
      r_seq       <= 8'h00;
      r_seq_snap  <= 8'h00;
      r_drop      <= 8'h00;
      r_drop_snap <= 8'h00;
    end else begin
      if (w_start) begin
        r_req       <= r_pend_v ? r_pend : w_req;
        r_cur       <= i_cur_state;
        r_fifo      <= 16'(i_fifo_used);
        // the frame that follows a completed one reports the already-incremented sequence number
        r_seq_snap  <= w_last_xfer ? r_seq + 8'd1 : r_seq;
        r_drop_snap <= r_drop;
        r_idx       <= 3'd0;
      end else if (o_tx_valid && i_tx_ready) begin
        r_idx <= r_idx + 3'd1;
      end
      if (w_last_xfer) r_seq <= r_seq + 8'd1;
      // when the slot feeds the new frame, a coincident request refills it instead of being dropped
      if (w_start && r_pend_v) begin
        r_pend_v <= i_req_valid;
        r_pend   <= w_req;
      end else if (!w_start && i_req_valid) begin
        if (!r_pend_v) begin
          r_pend_v <= 1'b1;
          r_pend   <= w_req;
        end else if (r_drop != 8'hFF) begin
          r_drop <= r_drop + 8'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_eth_tx_responder.sv
// tb_eth_tx_responder: scoreboard bench for eth_tx_responder with a queue-based reference model.
module tb_eth_tx_responder;
  logic        clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, tx_ready = 1'b0;
  logic [3:0]  req_cmd = 4'h0, req_data = 4'h0, cur_state = 4'h0;
  logic [10:0] fifo_used = 11'h000;
  logic [7:0]  tx_data, drop_count;
  logic        tx_valid, tx_last, busy;

  eth_tx_responder dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .i_req_cmd(req_cmd),
    .i_req_data(req_data), .i_cur_state(cur_state), .i_fifo_used(fifo_used),
    .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
    .o_tx_last(tx_last), .o_busy(busy), .o_drop_count(drop_count)
  );

  always #4 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  logic [8:0] exp_q[$];
  logic [7:0] cap[$];
  bit         cap_en = 0;
  int         m_rem = 0, m_seq = 0, m_drop = 0;
  logic [7:0] m_pend[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference frame: bytes built from the request and the status seen on the start edge
  task automatic start_frame(input logic [7:0] cd);
    logic [7:0] b[8];
    b[0] = 8'hA5;
    b[1] = cd;
    b[2] = {4'h0, cur_state};
    b[3] = 8'((fifo_used >> 8) & 11'h0FF);
    b[4] = 8'(fifo_used & 11'h0FF);
    b[5] = 8'(m_seq);
    b[6] = 8'(m_drop);
    b[7] = 8'h00;
    for (int i = 0; i < 7; i++) b[7] ^= b[i];
    for (int i = 0; i < 8; i++) exp_q.push_back({i == 7, b[i]});
    m_rem = 8;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_rem = 0; m_seq = 0; m_drop = 0;
      m_pend.delete(); exp_q.delete();
    end else begin
      if (m_rem > 0 && tx_ready) begin
        m_rem--;
        if (m_rem == 0) m_seq = (m_seq + 1) % 256;
      end
      if (m_rem == 0 && m_pend.size() > 0) start_frame(m_pend.pop_front());
      if (req_valid) begin
        if (m_rem == 0) start_frame({req_cmd, req_data});
        else if (m_pend.size() == 0) m_pend.push_back({req_cmd, req_data});
        else if (m_drop < 255) m_drop++;
      end
    end
  end

  logic [7:0] h_data;
  logic       h_last;
  bit         h_stall = 0;
  initial forever begin
    logic [8:0] e;
    @(negedge clk); #1;
    if (!rst_n) h_stall = 0;
    else begin
      chk("tx_valid", {31'h0, tx_valid}, {31'h0, m_rem > 0});
      chk("busy", {31'h0, busy}, {31'h0, m_rem > 0 || m_pend.size() > 0});
      chk("drop_count", {24'h0, drop_count}, m_drop);
      if (h_stall) begin
        chk("stall_data", {24'h0, tx_data}, {24'h0, h_data});
        chk("stall_last", {31'h0, tx_last}, {31'h0, h_last});
      end
      h_stall = tx_valid && !tx_ready;
      h_data  = tx_data;
      h_last  = tx_last;
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_byte: got %0h expected none", tx_data);
        end else begin
          e = exp_q.pop_front();
          chk("tx_data", {24'h0, tx_data}, {24'h0, e[7:0]});
          chk("tx_last", {31'h0, tx_last}, {31'h0, e[8]});
        end
        if (cap_en) cap.push_back(tx_data);
      end
    end
  end

  task automatic drain();
    int k = 0;
    @(negedge clk);
    req_valid = 0; tx_ready = 1;
    while ((m_rem > 0 || m_pend.size() > 0 || exp_q.size() > 0) && k < 300) begin
      @(negedge clk); k++;
    end
    chk("drain_idle", {31'h0, m_rem == 0 && m_pend.size() == 0 && exp_q.size() == 0}, 32'h1);
  endtask

  task automatic issue(input logic [3:0] c, input logic [3:0] d);
    @(negedge clk);
    req_valid = 1; req_cmd = c; req_data = d;
    @(negedge clk);
    req_valid = 0;
  endtask

  task automatic run_frame(input logic [63:0] exp, input bit bp);
    int k = 0;
    cap.delete(); cap_en = 1;
    @(negedge clk);
    cur_state = 4'h1; fifo_used = 11'h123; tx_ready = 1;
    req_valid = 1; req_cmd = 4'h1; req_data = 4'h3;
    @(negedge clk);
    req_valid = 0;
    while (cap.size() < 8 && k < 100) begin
      tx_ready = bp ? (k % 3 == 0) : 1'b1;
      k++;
      @(negedge clk);
    end
    cap_en = 0;
    if (cap.size() < 8) chk("frame_timeout", cap.size(), 8);
    else for (int i = 0; i < 8; i++) chk($sformatf("frame_byte%0d", i), {24'h0, cap[i]}, {24'h0, exp[63-8*i -: 8]});
    drain();
  endtask

  initial begin
    int k;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_tx_valid", {31'h0, tx_valid}, 0);
    chk("rst_tx_last", {31'h0, tx_last}, 0);
    chk("rst_tx_data", {24'h0, tx_data}, 0);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_drop", {24'h0, drop_count}, 0);
    @(negedge clk);
    rst_n = 1;
    run_frame(64'hA513010123000095, 0);
    run_frame(64'hA513010123010094, 1);
    issue(4'h4, 4'h5);
    issue(4'h2, 4'h0);
    issue(4'h6, 4'h7);
    chk("overflow_drop", {24'h0, drop_count}, 1);
    drain();
    issue(4'h8, 4'h9);
    issue(4'hA, 4'hB);
    k = 0;
    while (m_rem != 1 && k < 50) begin @(negedge clk); k++; end
    req_valid = 1; req_cmd = 4'hC; req_data = 4'hD;
    @(negedge clk);
    req_valid = 0;
    chk("simul_no_drop", {24'h0, drop_count}, 1);
    drain();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      req_valid = $urandom_range(0, 3) == 0;
      req_cmd = 4'($urandom); req_data = 4'($urandom);
      cur_state = 4'($urandom); fifo_used = 11'($urandom);
      tx_ready = $urandom_range(0, 3) != 0;
    end
    drain();
    for (int i = 0; i < 2200; i++) begin
      @(negedge clk);
      req_valid = 1; tx_ready = 1;
      req_cmd = 4'($urandom); req_data = 4'($urandom);
      cur_state = 4'($urandom); fifo_used = 11'($urandom);
    end
    drain();
    issue(4'h3, 4'h3);
    k = 0;
    while (m_rem != 4 && k < 50) begin @(negedge clk); k++; end
    chk("reach_index4", m_rem, 4);
    #2 rst_n = 0;
    #1;
    chk("midrst_tx_valid", {31'h0, tx_valid}, 0);
    chk("midrst_tx_last", {31'h0, tx_last}, 0);
    chk("midrst_tx_data", {24'h0, tx_data}, 0);
    chk("midrst_busy", {31'h0, busy}, 0);
    chk("midrst_drop", {24'h0, drop_count}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    run_frame(64'hA513010123000095, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/eth_tx_responder.md
Name: eth_tx_responder

Overview:
Builds fixed 8-byte reply packets toward the Ethernet MAC transmit byte stream. It is the transmit-side counterpart of the rx command parser. Each accepted request (command and data nibbles from the parser/state manager) produces one reply frame. The frame echoes the request and reports the current state, the video_out FIFO fill level, a sequence number, the dropped-request count and an XOR checksum. It sits between the state manager and the MAC tx interface, in the 125 MHz Ethernet clock domain.

Parameters:
HDR_BYTE, 8'hA5, constant first byte of every reply
FIFO_USED_W, 11, width of the FIFO fill-level input (must be ≤16)

Ports:
clk  in  1  125 MHz Ethernet clock
rst  in  1  asynchronous reset, active-low
req_valid  in  1  one-cycle request strobe
req_cmd  in  4  command nibble to echo
req_data  in  4  data nibble to echo
cur_state  in  4  state manager's current_state
fifo_used  in  FIFO_USED_W  video_out FIFO used words
tx_data  out  8  reply byte
tx_valid  out  1  tx_data valid
tx_ready  in  1  MAC accepts byte this cycle
tx_last  out  1  high with final byte (index 7)
busy  out  1  packet in progress or request pending
drop_count  out  8  saturating count of dropped requests

Behaviour:
- Reset (rst=0, asynchronous): tx_valid=0, tx_last=0, tx_data=0, busy=0, drop_count=0, seq=0, byte index=0, pending slot empty, FSM=IDLE.
- Byte transfer occurs on a clk edge where tx_valid && tx_ready. While tx_valid && !tx_ready, tx_data, tx_last and the byte index hold stable.
- Packet layout (index: content):
  - 0: HDR_BYTE
  - 1: {req_cmd, req_data}
  - 2: {4'h0, cur_state}
  - 3: upper bits of fifo_used, zero-padded (fifo_used[10:8] for the default width)
  - 4: fifo_used[7:0]
  - 5: seq
  - 6: drop_count
  - 7: XOR of bytes 0–6
- cur_state, fifo_used, seq and drop_count are snapshotted on the cycle the packet starts and held for the whole frame. The checksum is computed from the snapshot.
- FSM:
  - IDLE: if req_valid (or the pending slot is full), latch cmd/data and snapshot. Next state SEND, index=0. tx_valid=1 on the following cycle.
  - Latency: req_valid sampled at edge N gives tx_valid=1 with byte 0 after edge N.
  - SEND: advance the index on each transfer. On the transfer of index 7 (tx_last=1): seq increments (8-bit wrap, 255→0).
    - If the pending slot is full: start the next packet from it with a new snapshot, and tx_valid stays 1 with the new byte 0 on the next cycle (no idle gap).
    - Otherwise go to IDLE with tx_valid=0.
- Request queuing: one-deep pending slot.
  - req_valid in SEND with the slot empty: store the request in the slot.
  - req_valid in SEND with the slot full: drop the request and increment drop_count, saturating at 8'hFF.
  - req_valid on the same edge as the final-byte transfer with the slot full: the slot's content moves to active and the new request fills the slot. Nothing is dropped.
  - req_valid on the same edge as the final-byte transfer with the slot empty: the new request starts the next packet immediately.
- busy = (FSM != IDLE) || slot full.
- drop_count snapshot: a drop occurring during a frame appears in the next frame, not in the current one.
- Reset mid-packet: the frame is abandoned immediately and tx_valid falls asynchronously. No tx_last is emitted for the partial frame; the MAC discards it.

Test Plan:
- Single request, tx_ready=1: req_cmd=1, req_data=3, cur_state=1, fifo_used=11'h123 after reset → bytes A5,13,01,01,23,00,00,95. tx_last only on 95. tx_valid is high exactly 8 cycles starting 1 cycle after req_valid.
- Backpressure: same request, tx_ready toggling 1,0,0,1,… → identical byte sequence. tx_data/tx_last stable during every stall cycle. Index never skips.
- Back-to-back: second req (cmd=2, data=0) during the first packet → second frame follows with no gap. Byte1=20, seq byte=01, tx_valid never drops between frames.
- Overflow: three requests during one packet → first completes, second queued, third dropped. drop_count=1 after the drop. Second frame's byte6=01, checksum correct.
- Simultaneous final-byte and request with slot full → no drop (drop_count unchanged), three frames emitted in order.
- Wrap and reset: 256 packets → seq byte cycles 00..FF then 00. rst low at index 4 of a frame → tx_valid=0 immediately. After rst release the next request gives seq=00, drop_count=00.
